// File: rtl/axis_sample_framer_if.sv
// AXI-Stream byte channel used by axis_sample_framer.
// master drives data/valid/last/user, slave drives ready.
interface axis_sample_framer_if;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tready;
   logic       tlast;
   logic       tuser;

   modport master (
      output tdata, tvalid, tlast, tuser,
      input  tready
   );

   modport slave (
      input  tdata, tvalid, tlast, tuser,
      output tready
   );
endinterface

// File: rtl/axis_sample_framer.sv
// Packs a free-running sample stream into header+payload AXIS byte frames.
// AXIS_FRAMER_CHECKSUM_EN appends a modulo-256 checksum byte to each frame.
module axis_sample_framer #(
   parameter int          SAMPLE_WIDTH      = 16,
   parameter int          SAMPLES_PER_FRAME = 256,
   parameter int          FIFO_DEPTH        = 16,
   parameter logic [15:0] MAGIC             = 16'hA55A
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic [SAMPLE_WIDTH-1:0] sample_data,
   input  logic                    sample_valid,
   axis_sample_framer_if.master    m_axis,
   output logic [15:0]             status_overflow_cnt,
   output logic                    status_busy
);

   localparam int SB = SAMPLE_WIDTH / 8;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = (SB > 1) ? $clog2(SB) : 1;
   localparam int NW = (SAMPLES_PER_FRAME > 1) ?
                       $clog2(SAMPLES_PER_FRAME) : 1;

   typedef enum logic [1:0] {
      IDLE,
      HDR,
`ifdef AXIS_FRAMER_CHECKSUM_EN
      DATA,
      CSUM
`else
      DATA
`endif
   } state_t;

   state_t                  state_q;
   logic [SAMPLE_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]             wr_q, rd_q;
   logic [1:0]              hdr_q;
   logic [BW-1:0]           byte_q;
   logic [NW-1:0]           smp_q;
   logic [SAMPLE_WIDTH-1:0] sh_q;
   logic [15:0]             seq_q;
   logic [15:0]             ovf_q;
   logic                    drop_q;
   logic [7:0]              tdata_q;
   logic                    tvalid_q, tlast_q, tuser_q;
`ifdef AXIS_FRAMER_CHECKSUM_EN
   logic [7:0]              csum_q;
`endif

   logic                    empty, full, push, drop, pop;
   logic                    load_ok, hs, byte0, data_go;
   logic                    last_byte, last_smp;
   logic [SAMPLE_WIDTH-1:0] head;
   logic [7:0]              data_byte, hdr_byte;

   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) &&
                  (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign push  = sample_valid && enable && !full;
   assign drop  = sample_valid && enable && full;
   assign head  = mem_q[rd_q[AW-1:0]];

   assign load_ok   = !tvalid_q || m_axis.tready;
   assign hs        = tvalid_q && m_axis.tready;
   assign byte0     = (byte_q == '0);
   assign last_byte = (byte_q == BW'(SB - 1));
   assign last_smp  = (smp_q == NW'(SAMPLES_PER_FRAME - 1));
   assign data_go   = (state_q == DATA) && load_ok &&
                      (!byte0 || !empty);
   assign pop       = data_go && byte0;
   assign data_byte = byte0 ? head[SAMPLE_WIDTH-1 -: 8]
                            : sh_q[SAMPLE_WIDTH-1 -: 8];

   // Header byte selected by position within the 4-byte header.
   always_comb begin
      hdr_byte = MAGIC[15:8];
      case (hdr_q)
         2'd0:    hdr_byte = MAGIC[15:8];
         2'd1:    hdr_byte = MAGIC[7:0];
         2'd2:    hdr_byte = seq_q[15:8];
         default: hdr_byte = seq_q[7:0];
      endcase
   end

   // Sample storage; contents need no reset, pointers define validity.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q[AW-1:0]] <= sample_data;
   end

   // FIFO pointers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_q + (AW + 1)'(push);
         rd_q <= rd_q + (AW + 1)'(pop);
      end
   end

   // Drop accounting and frame sequence number.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q  <= '0;
         drop_q <= 1'b0;
         seq_q  <= '0;
      end else begin
         if (drop && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
         if (drop)               drop_q <= 1'b1;
         else if (hs && tlast_q) drop_q <= 1'b0;
         if (hs && tlast_q) seq_q <= seq_q + 16'd1;
      end
   end

   // Frame FSM with the registered AXIS output stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         hdr_q    <= '0;
         byte_q   <= '0;
         smp_q    <= '0;
         sh_q     <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tuser_q  <= 1'b0;
`ifdef AXIS_FRAMER_CHECKSUM_EN
         csum_q   <= '0;
`endif
      end else begin
         if (load_ok) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
         end
         unique case (state_q)
            IDLE: begin
               hdr_q  <= '0;
               byte_q <= '0;
               smp_q  <= '0;
`ifdef AXIS_FRAMER_CHECKSUM_EN
               csum_q <= '0;
`endif
               if (!empty) state_q <= HDR;
            end
            HDR: begin
               if (load_ok) begin
                  tvalid_q <= 1'b1;
                  tdata_q  <= hdr_byte;
`ifdef AXIS_FRAMER_CHECKSUM_EN
                  csum_q   <= csum_q + hdr_byte;
`endif
                  hdr_q    <= hdr_q + 2'd1;
                  if (hdr_q == 2'd3) state_q <= DATA;
               end
            end
            DATA: begin
               if (data_go) begin
                  tvalid_q <= 1'b1;
                  tdata_q  <= data_byte;
`ifdef AXIS_FRAMER_CHECKSUM_EN
                  csum_q   <= csum_q + data_byte;
`endif
                  sh_q     <= (byte0 ? head : sh_q) << 8;
                  if (last_byte) begin
                     byte_q <= '0;
                     smp_q  <= smp_q + NW'(1);
                     if (last_smp) begin
`ifdef AXIS_FRAMER_CHECKSUM_EN
                        state_q <= CSUM;
`else
                        tlast_q <= 1'b1;
                        tuser_q <= drop_q;
                        state_q <= IDLE;
`endif
                     end
                  end else begin
                     byte_q <= byte_q + BW'(1);
                  end
               end
            end
`ifdef AXIS_FRAMER_CHECKSUM_EN
            CSUM: begin
               if (load_ok) begin
                  tvalid_q <= 1'b1;
                  tdata_q  <= csum_q;
                  tlast_q  <= 1'b1;
                  tuser_q  <= drop_q;
                  state_q  <= IDLE;
               end
            end
`endif
            default: state_q <= IDLE;
         endcase
      end
   end

   assign m_axis.tdata        = tdata_q;
   assign m_axis.tvalid       = tvalid_q;
   assign m_axis.tlast        = tlast_q;
   assign m_axis.tuser        = tuser_q;
   assign status_overflow_cnt = ovf_q;
   assign status_busy         = (state_q != IDLE);

endmodule
